gpio_bank_controller: RTL and testbench

- Parametrised next-generation GPIO bank for the peripheral bus.
- One instance drives IO_COUNT pads and provides:
  - direction, output and set/clear/toggle registers;
  - synchronised, optionally debounced inputs;
  - per-pin rising/falling-edge interrupts with a sticky W1C status and a single IRQ line.
- Instantiated (one or more times) inside the GPIO peripheral top, behind PeripheralSelect, on the 16-bit local address.

---
 rtl/gpio_bank_controller.sv | 150 +++++++++++++++
 tb/tb_gpio_bank_controller.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank_controller.sv
// GPIO bank: OE/OUT registers with set/clear/toggle aliases, synchronised and optionally
// debounced inputs, per-pin edge interrupts with sticky W1C status and a registered IRQ.
module gpio_bank_controller #(
  parameter logic [3:0] ID             = 4'h1,
  parameter int         IO_COUNT       = 32,
  parameter int         SYNC_STAGES    = 2,
  parameter int         DEBOUNCE_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                peripheralEnable,
  input  logic                peripheralBus_we,
  input  logic                peripheralBus_oe,
  output logic                peripheralBus_busy,
  input  logic [15:0]         peripheralBus_address,
  input  logic [3:0]          peripheralBus_byteSelect,
  input  logic [31:0]         peripheralBus_dataWrite,
  output logic [31:0]         peripheralBus_dataRead,
  output logic                requestOutput,
  input  logic [IO_COUNT-1:0] gpio_input,
  output logic [IO_COUNT-1:0] gpio_output,
  output logic [IO_COUNT-1:0] gpio_oe,
  output logic                gpio_irq
);
  localparam logic [9:0] OFS_OE     = 10'd0;
  localparam logic [9:0] OFS_OUT    = 10'd1;
  localparam logic [9:0] OFS_SET    = 10'd2;
  localparam logic [9:0] OFS_CLR    = 10'd3;
  localparam logic [9:0] OFS_TGL    = 10'd4;
  localparam logic [9:0] OFS_IN     = 10'd5;
  localparam logic [9:0] OFS_RISE   = 10'd6;
  localparam logic [9:0] OFS_FALL   = 10'd7;
  localparam logic [9:0] OFS_STATUS = 10'd8;
  localparam logic [9:0] OFS_DEB    = 10'd9;

  logic [IO_COUNT-1:0]                  r_oe, r_out, r_rise_en, r_fall_en, r_status;
  logic [IO_COUNT-1:0]                  r_samp, r_filt;
  logic [SYNC_STAGES-1:0][IO_COUNT-1:0] r_sync;
  logic [DEBOUNCE_WIDTH-1:0]            r_debounce, r_tick_cnt;
  logic                                 r_irq;

  logic                      w_sel, w_wr, w_deb_wr, w_deb_on, w_tick, w_unused;
  logic [9:0]                w_ofs;
  logic [31:0]               w_mask32, w_rdata;
  logic [IO_COUNT-1:0]       w_mask, w_bits, w_sync, w_filt_next, w_event, w_status_next;
  logic [DEBOUNCE_WIDTH-1:0] w_deb_mask, w_deb_wdat;

  assign w_sel      = peripheralEnable && (peripheralBus_address[15:12] == ID);
  assign w_ofs      = peripheralBus_address[11:2];
  assign w_wr       = w_sel && peripheralBus_we;
  assign w_mask32   = {{8{peripheralBus_byteSelect[3]}}, {8{peripheralBus_byteSelect[2]}},
                       {8{peripheralBus_byteSelect[1]}}, {8{peripheralBus_byteSelect[0]}}};
  assign w_mask     = w_mask32[IO_COUNT-1:0];
  assign w_bits     = peripheralBus_dataWrite[IO_COUNT-1:0] & w_mask;
  assign w_deb_mask = w_mask32[DEBOUNCE_WIDTH-1:0];
  assign w_deb_wdat = peripheralBus_dataWrite[DEBOUNCE_WIDTH-1:0];
  assign w_deb_wr   = w_wr && (w_ofs == OFS_DEB);
  assign w_unused   = &{1'b0, peripheralBus_address[1:0], w_mask32, peripheralBus_dataWrite};

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_deb_on = (r_debounce != '0);
  assign w_tick   = w_deb_on && (r_tick_cnt == r_debounce - DEBOUNCE_WIDTH'(1));

  // On a tick a pin is accepted only if it matches the sample taken at the previous tick.
  always_comb begin
    w_filt_next = r_filt;
    if (w_deb_wr) begin
      w_filt_next = r_filt;
    end else if (!w_deb_on) begin
      w_filt_next = w_sync;
    end else if (w_tick) begin
      w_filt_next = (w_sync & r_samp) | (r_filt & (w_sync ^ r_samp));
    end
  end

  assign w_event = (w_filt_next & ~r_filt & r_rise_en) | (~w_filt_next & r_filt & r_fall_en);

  // A new event overrides a simultaneous W1C of the same bit.
  always_comb begin
    w_status_next = r_status;
    if (w_wr && (w_ofs == OFS_STATUS)) begin
      w_status_next = r_status & ~w_bits;
    end
    w_status_next = w_status_next | w_event;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_oe       <= '0;
      r_out      <= '0;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_status   <= '0;
      r_samp     <= '0;
      r_filt     <= '0;
      r_sync     <= '0;
      r_debounce <= '0;
      r_tick_cnt <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], gpio_input};
      r_filt   <= w_filt_next;
      r_status <= w_status_next;
      r_irq    <= |w_status_next;
      if (w_deb_wr) begin
        r_tick_cnt <= '0;
        r_samp     <= '0;
      end else if (w_tick) begin
        r_tick_cnt <= '0;
        r_samp     <= w_sync;
      end else if (w_deb_on) begin
        r_tick_cnt <= r_tick_cnt + DEBOUNCE_WIDTH'(1);
      end
      if (w_wr) begin
        case (w_ofs)
          OFS_OE:   r_oe       <= (r_oe & ~w_mask) | w_bits;
          OFS_OUT:  r_out      <= (r_out & ~w_mask) | w_bits;
          OFS_SET:  r_out      <= r_out | w_bits;
          OFS_CLR:  r_out      <= r_out & ~w_bits;
          OFS_TGL:  r_out      <= r_out ^ w_bits;
          OFS_RISE: r_rise_en  <= (r_rise_en & ~w_mask) | w_bits;
          OFS_FALL: r_fall_en  <= (r_fall_en & ~w_mask) | w_bits;
          OFS_DEB:  r_debounce <= (r_debounce & ~w_deb_mask) | (w_deb_wdat & w_deb_mask);
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_ofs)
      OFS_OE:     w_rdata = 32'(r_oe);
      OFS_OUT:    w_rdata = 32'(r_out);
      OFS_IN:     w_rdata = 32'(r_filt);
      OFS_RISE:   w_rdata = 32'(r_rise_en);
      OFS_FALL:   w_rdata = 32'(r_fall_en);
      OFS_STATUS: w_rdata = 32'(r_status);
      OFS_DEB:    w_rdata = 32'(r_debounce);
      default:    w_rdata = '0;
    endcase
  end

  assign requestOutput          = w_sel && peripheralBus_oe;
  assign peripheralBus_dataRead = requestOutput ? w_rdata : 32'h0;
  assign peripheralBus_busy     = 1'b0;
  assign gpio_output            = r_out;
  assign gpio_oe                = r_oe;
  assign gpio_irq               = r_irq;
endmodule

// File: tb/tb_gpio_bank_controller.sv
// Bench for gpio_bank_controller: directed scenarios followed by random bus and pad traffic,
// compared against a cycle-level reference model of the register and input-filter rules.
module tb_gpio_bank_controller;
  localparam logic [3:0] ID = 4'h1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        peripheralEnable = 1'b0, peripheralBus_we = 1'b0, peripheralBus_oe = 1'b0;
  logic        peripheralBus_busy, requestOutput, gpio_irq;
  logic [15:0] peripheralBus_address = '0;
  logic [3:0]  peripheralBus_byteSelect = '0;
  logic [31:0] peripheralBus_dataWrite = '0, peripheralBus_dataRead;
  logic [31:0] gpio_input = '0, gpio_output, gpio_oe;

  gpio_bank_controller #(.ID(ID), .IO_COUNT(32), .SYNC_STAGES(2), .DEBOUNCE_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .peripheralEnable(peripheralEnable),
    .peripheralBus_we(peripheralBus_we), .peripheralBus_oe(peripheralBus_oe),
    .peripheralBus_busy(peripheralBus_busy), .peripheralBus_address(peripheralBus_address),
    .peripheralBus_byteSelect(peripheralBus_byteSelect),
    .peripheralBus_dataWrite(peripheralBus_dataWrite),
    .peripheralBus_dataRead(peripheralBus_dataRead), .requestOutput(requestOutput),
    .gpio_input(gpio_input), .gpio_output(gpio_output), .gpio_oe(gpio_oe), .gpio_irq(gpio_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  logic [31:0] pins = '0;
  logic        cap_req;
  logic [31:0] cap_rd;
  logic [31:0] exp_q[$];

  // Reference state
  logic [31:0] m_oe = '0, m_out = '0, m_rise = '0, m_fall = '0, m_status = '0;
  logic [31:0] m_filt = '0, m_samp = '0;
  logic [7:0]  m_deb = '0;
  int          m_phase = 0;
  logic        m_irq = 1'b0;
  logic [31:0] hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s got %0d expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  function automatic logic [31:0] model_read(input int ofs);
    case (ofs)
      0:       return m_oe;
      1:       return m_out;
      5:       return m_filt;
      6:       return m_rise;
      7:       return m_fall;
      8:       return m_status;
      9:       return {24'h0, m_deb};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic en, input logic we, input logic [15:0] a,
                            input logic [3:0] bs, input logic [31:0] wd, input logic [31:0] p);
    logic [31:0] m, b, s, fn, st;
    logic        wr, tick;
    int          ofs;
    if (r) begin
      m_oe = 0; m_out = 0; m_rise = 0; m_fall = 0; m_status = 0;
      m_filt = 0; m_samp = 0; m_deb = 0; m_phase = 0; m_irq = 0;
      hist.delete();
      hist.push_back(32'h0);
      hist.push_back(32'h0);
    end else begin
      s    = hist[0];
      wr   = en && we && (a[15:12] == ID);
      ofs  = int'(a[11:2]);
      for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{bs[i]}};
      b    = wd & m;
      tick = (m_deb != 0) && (m_phase == int'(m_deb) - 1);
      fn   = m_filt;
      if (wr && ofs == 9) fn = m_filt;
      else if (m_deb == 0) fn = s;
      else if (tick) for (int i = 0; i < 32; i++) if (s[i] == m_samp[i]) fn[i] = s[i];
      st = m_status;
      if (wr && ofs == 8) st = st & ~b;
      for (int i = 0; i < 32; i++)
        if ((fn[i] && !m_filt[i] && m_rise[i]) || (!fn[i] && m_filt[i] && m_fall[i])) st[i] = 1'b1;
      if (wr && ofs == 9) begin m_phase = 0; m_samp = 0; end
      else if (tick) begin m_phase = 0; m_samp = s; end
      else if (m_deb != 0) m_phase++;
      if (wr) begin
        case (ofs)
          0: m_oe   = (m_oe & ~m) | b;
          1: m_out  = (m_out & ~m) | b;
          2: m_out  = m_out | b;
          3: m_out  = m_out & ~b;
          4: m_out  = m_out ^ b;
          6: m_rise = (m_rise & ~m) | b;
          7: m_fall = (m_fall & ~m) | b;
          9: m_deb  = (m_deb & ~m[7:0]) | b[7:0];
          default: ;
        endcase
      end
      m_filt   = fn;
      m_status = st;
      m_irq    = (st != 0);
      hist.push_back(p);
      void'(hist.pop_front());
    end
  endtask

  task automatic cyc(input logic en, input logic we, input logic oe, input logic [15:0] a,
                     input logic [3:0] bs, input logic [31:0] wd);
    peripheralEnable = en; peripheralBus_we = we; peripheralBus_oe = oe;
    peripheralBus_address = a; peripheralBus_byteSelect = bs; peripheralBus_dataWrite = wd;
    gpio_input = pins;
    if (en && oe && a[15:12] == ID) exp_q.push_back(model_read(int'(a[11:2])));
    #1;
    cap_req = requestOutput;
    cap_rd  = peripheralBus_dataRead;
    @(posedge clk);
    model_step(rst, en, we, a, bs, wd, pins);
    #1;
  endtask

  task automatic wr(input logic [11:0] ofs, input logic [31:0] d, input logic [3:0] bs = 4'hF);
    cyc(1'b1, 1'b1, 1'b0, {ID, ofs}, bs, d);
  endtask

  task automatic rd(input logic [11:0] ofs);
    cyc(1'b1, 1'b0, 1'b1, {ID, ofs}, 4'h0, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
  endtask

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (requestOutput) begin
          if (exp_q.size() == 0) chk("unexpected_read", 32'h1, 32'h0);
          else begin
            e = exp_q.pop_front();
            chk("read_data", peripheralBus_dataRead, e);
          end
        end else begin
          chk("idle_dataRead", peripheralBus_dataRead, 32'h0);
        end
        chk("gpio_oe", gpio_oe, m_oe);
        chk("gpio_output", gpio_output, m_out);
        chk("gpio_irq", {31'h0, gpio_irq}, {31'h0, m_irq});
        chk("busy", {31'h0, peripheralBus_busy}, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset values and readback
    for (int o = 0; o <= 9; o++) begin
      rd(12'(o * 4));
      chk("reset_read", cap_rd, 32'h0);
    end
    chk("reset_irq", {31'h0, gpio_irq}, 32'h0);
    wr(12'h000, 32'hFFFF_FFFF, 4'b0101);
    chk("oe_bytesel", gpio_oe, 32'h00FF_00FF);
    rd(12'h000);
    chk("oe_read", cap_rd, 32'h00FF_00FF);
    rd(12'h028);
    chk("unmapped_req", {31'h0, cap_req}, 32'h1);
    chk("unmapped_data", cap_rd, 32'h0);

    // Set / clear / toggle
    wr(12'h004, 32'h0000_00F0);
    wr(12'h008, 32'h0000_000F);
    chk("out_set", gpio_output, 32'h0000_00FF);
    wr(12'h00C, 32'h0000_0030);
    chk("out_clr", gpio_output, 32'h0000_00CF);
    wr(12'h010, 32'h0000_0101);
    chk("out_tgl", gpio_output, 32'h0000_01CE);
    rd(12'h008);
    chk("set_reads0", cap_rd, 32'h0);

    // Device select decode
    cyc(1'b1, 1'b1, 1'b0, 16'h2004, 4'hF, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 16'h1004, 4'hF, 32'h0);
    chk("wrong_sel_write", gpio_output, 32'h0000_01CE);
    cyc(1'b1, 1'b0, 1'b1, 16'h2004, 4'h0, 32'h0);
    chk("wrong_id_req", {31'h0, cap_req}, 32'h0);
    chk("wrong_id_data", cap_rd, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 16'h1004, 4'h0, 32'h0);
    chk("no_enable_req", {31'h0, cap_req}, 32'h0);

    // Rising-edge interrupt, no debounce
    wr(12'h018, 32'h8);
    pins[3] = 1'b1;
    idle(2);
    chk("rise_irq_early", {31'h0, gpio_irq}, 32'h0);
    idle(1);
    chk("rise_irq", {31'h0, gpio_irq}, 32'h1);
    rd(12'h020);
    chk("rise_status", cap_rd, 32'h8);
    rd(12'h014);
    chk("rise_in", cap_rd, 32'h8);
    pins[3] = 1'b0;
    idle(4);
    rd(12'h020);
    chk("fall_not_enabled", cap_rd, 32'h8);
    wr(12'h020, 32'h8);
    chk("w1c_irq", {31'h0, gpio_irq}, 32'h0);

    // W1C colliding with a new falling event
    wr(12'h01C, 32'h1);
    pins[0] = 1'b1; idle(4);
    pins[0] = 1'b0; idle(4);
    rd(12'h020);
    chk("fall_status", cap_rd, 32'h1);
    pins[0] = 1'b1; idle(4);
    pins[0] = 1'b0; idle(2);
    wr(12'h020, 32'h1);
    chk("collision_irq", {31'h0, gpio_irq}, 32'h1);
    rd(12'h020);
    chk("collision_status", cap_rd, 32'h1);
    wr(12'h020, 32'h1);
    chk("clear_after_collision", {31'h0, gpio_irq}, 32'h0);

    // Debounce = 4
    wr(12'h024, 32'h4);
    wr(12'h018, 32'h20);
    pins[5] = 1'b1; idle(3);
    pins[5] = 1'b0; idle(20);
    rd(12'h014);
    chk("glitch_in", cap_rd, 32'h0);
    chk("glitch_irq", {31'h0, gpio_irq}, 32'h0);
    pins[5] = 1'b1;
    n = 0;
    while (n < 30 && !gpio_irq) begin
      idle(1);
      n++;
    end
    chk_rng("debounce_latency", n, 7, 11);
    rd(12'h014);
    chk("debounce_in", cap_rd, 32'h20);

    // Reset with pad held high
    rst = 1'b1; idle(1); rst = 1'b0;
    idle(4);
    chk("post_reset_irq", {31'h0, gpio_irq}, 32'h0);
    rd(12'h014);
    chk("post_reset_in", cap_rd, 32'h20);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int k;
      logic [11:0] ofs;
      k = $urandom_range(0, 19);
      if ($urandom_range(0, 3) == 0) pins = pins ^ (32'h1 << $urandom_range(0, 7));
      if (k == 0) begin
        rst = 1'b1; idle(1); rst = 1'b0;
      end else if (k < 8) begin
        ofs = 12'($urandom_range(0, 9) * 4);
        if (ofs == 12'h024) wr(ofs, 32'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        else wr(ofs, $urandom, 4'($urandom_range(0, 15)));
      end else if (k < 14) begin
        rd(12'($urandom_range(0, 15) * 4));
      end else if (k == 14) begin
        cyc(1'b1, 1'b1, 1'b0, {4'h3, 12'($urandom_range(0, 9) * 4)}, 4'hF, $urandom);
      end else begin
        idle(1);
      end
    end

    idle(2);
    chk("read_queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
